pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter RST_PULSE_CYC, default 16: refclk cycles of pll_rst assertion per PLL restart (1..65535).
REQ-002 The block SHALL have parameter LOCK_STABLE_CYC, default 1024: consecutive locked cycles required before release (1..65535).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT_CYC, default 65535: cycles allowed in WAIT_LOCK before a retry (1..65535).
REQ-004 The block SHALL have parameter MAX_RETRY, default 3: timeouts tolerated before FAULT (1..3).
REQ-005 The block SHALL have port refclk, input, 1: the single clock, the 50 MHz PLL reference.
REQ-006 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port pll_locked, input, 1: PLL lock indication, asynchronous to refclk.
REQ-008 The block SHALL have port restart_req, input, 1: single-cycle request to restart the PLL sequence.
REQ-009 The block SHALL have port pll_rst, output, 1: active-high reset to the PLL.
REQ-010 The block SHALL have port sys_reset, output, 1: active-high reset to the core logic.
REQ-011 The block SHALL have port ready, output, 1: high only in RUN.
REQ-012 The block SHALL have port fault, output, 1: high only in FAULT.
REQ-013 The block SHALL have port retry_cnt, output, 2: number of lock timeouts since the last clean start.
REQ-014 The block SHALL have port lock_lost, output, 1: sticky flag for a lock loss seen in RUN.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); only locked_s SHALL be used by the FSM.
REQ-016 The FSM states SHALL be RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT, with a single 16-bit cycle counter cleared on every state entry.
REQ-017 All outputs SHALL be registered and decoded from the next state, so that they change on the same edge as the state.
REQ-018 In RESET_PLL, pll_rst SHALL be 1 for exactly RST_PULSE_CYC cycles, after which the FSM SHALL enter WAIT_LOCK.
REQ-019 In WAIT_LOCK, pll_rst SHALL be 0; locked_s=1 SHALL enter STABLE.
REQ-020 In WAIT_LOCK, after LOCK_TIMEOUT_CYC cycles without lock, retry_cnt SHALL increment; if the new value equals MAX_RETRY the FSM SHALL enter FAULT, otherwise RESET_PLL.
REQ-021 In STABLE, locked_s=0 SHALL return the FSM to WAIT_LOCK with the timeout restarted and retry_cnt unchanged.
REQ-022 In STABLE, when the counter reaches LOCK_STABLE_CYC-1 with locked_s=1, the FSM SHALL enter RUN.
REQ-023 ready SHALL rise on the (LOCK_STABLE_CYC+3)th refclk edge after pll_locked rises while in WAIT_LOCK.
REQ-024 sys_reset SHALL be 1 in every state except RUN.
REQ-025 In RUN, locked_s=0 SHALL set lock_lost and enter RESET_PLL; retry_cnt SHALL be unchanged.
REQ-026 In FAULT, pll_rst SHALL be 1 and fault SHALL be 1; FAULT SHALL be left only through restart_req.
REQ-027 restart_req in any state SHALL enter RESET_PLL, clear retry_cnt and clear lock_lost, and SHALL take priority over all other transitions in the same cycle.
REQ-028 retry_cnt SHALL saturate at 3 and SHALL never wrap.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a refclk edge, force state RESET_PLL, counter 0, synchronizer 0, pll_rst=1, sys_reset=1, ready=0, fault=0, retry_cnt=0 and lock_lost=0.
REQ-030 rst_n deasserted SHALL start a full RST_PULSE_CYC pulse on pll_rst, and reset asserted mid-sequence SHALL discard all progress.

Verification (params 4/8/32/3)
REQ-031 Release rst_n with pll_locked=1 and held -> pll_rst high 4 cycles, then ready=1 and sys_reset=0 on the 11th edge after WAIT_LOCK entry.
REQ-032 Drop pll_locked for 1 cycle at STABLE count 5 -> return to WAIT_LOCK, no ready pulse, and ready 11 edges after pll_locked returns.
REQ-033 Hold pll_locked=0 -> three 32-cycle WAIT_LOCK windows separated by 4-cycle pll_rst pulses, then fault=1, retry_cnt=3, pll_rst=1 held.
REQ-034 Drop pll_locked in RUN -> ready=0 and sys_reset=1 by the 3rd edge, lock_lost=1, pll_rst pulse of 4 cycles.
REQ-035 Pulse restart_req in FAULT, and also in the same cycle as a timeout -> RESET_PLL, retry_cnt=0, fault=0, lock_lost=0.
REQ-036 Assert rst_n=0 mid-WAIT_LOCK between clock edges -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL start-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the core reset. Retries on lock timeout and parks in FAULT after MAX_RETRY.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65535,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic       lock_lost
);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_e;

  localparam logic [15:0] RST_LAST     = 16'(RST_PULSE_CYC - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        meta_q, meta_d;
  logic        locked_s_q, locked_s_d;
  logic [1:0]  retry_q, retry_d, retry_inc;
  logic        lock_lost_q, lock_lost_d;
  logic        pll_rst_q, sys_reset_q, ready_q, fault_q;

  // The lock flag is meaningless while the PLL is held in reset, so the
  // synchronizer is flushed there and only sees lock once the PLL runs.
  always_comb begin
    meta_d     = pll_locked;
    locked_s_d = meta_q;
    if (state_q == RESET_PLL || state_q == FAULT) begin
      meta_d     = 1'b0;
      locked_s_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    retry_inc   = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!locked_s_q) begin
          lock_lost_d = 1'b1;
          state_d     = RESET_PLL;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    if (restart_req) begin
      state_d     = RESET_PLL;
      retry_d     = 2'd0;
      lock_lost_d = 1'b0;
    end

    // A restart from RESET_PLL re-enters the state and must restart the pulse.
    cnt_d = (state_d != state_q || restart_req) ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= 16'd0;
      meta_q      <= 1'b0;
      locked_s_q  <= 1'b0;
      retry_q     <= 2'd0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      meta_q      <= meta_d;
      locked_s_q  <= locked_s_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_rst_q   <= (state_d == RESET_PLL) || (state_d == FAULT);
      sys_reset_q <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: each scenario predicts the edge and value of every output
// change from the timing rules; a negedge monitor pops and compares on each change.
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int TO = 32;
  localparam int MR = 3;
  localparam logic [6:0] RESET_VEC = 7'b1100000;

  logic       refclk      = 1'b0;
  logic       rst_n       = 1'b1;
  logic       pll_locked  = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_rst, sys_reset, ready, fault, lock_lost;
  logic [1:0] retry_cnt;

  typedef struct {
    int         at_edge;
    logic [6:0] vec;
  } ev_t;

  ev_t        exp_q[$];
  int         edge_n      = 0;
  int         checks      = 0;
  int         errors      = 0;
  logic [6:0] last_vec    = RESET_VEC;
  logic [6:0] last_pushed = RESET_VEC;
  logic       e_pll_rst, e_sys, e_ready, e_fault, e_lost;
  logic [1:0] e_retry;

  pll_lock_sequencer #(
    .RST_PULSE_CYC(RP),
    .LOCK_STABLE_CYC(LS),
    .LOCK_TIMEOUT_CYC(TO),
    .MAX_RETRY(MR)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .restart_req(restart_req),
    .pll_rst(pll_rst),
    .sys_reset(sys_reset),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .lock_lost(lock_lost)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) edge_n++;

  function automatic logic [6:0] dut_vec();
    return {pll_rst, sys_reset, ready, fault, retry_cnt, lock_lost};
  endfunction

  always @(negedge refclk) begin
    logic [6:0] v;
    ev_t        ev;
    v = dut_vec();
    if (v !== last_vec) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_change edge %0d got %b prev %b", edge_n, v, last_vec);
      end else begin
        ev = exp_q.pop_front();
        if (ev.at_edge != edge_n || ev.vec !== v) begin
          errors++;
          $display("[TB] FAIL output_event got edge %0d vec %b, expected edge %0d vec %b",
                   edge_n, v, ev.at_edge, ev.vec);
        end
      end
      last_vec = v;
    end
  end

  task automatic check_output(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic reset_exp();
    e_pll_rst = 1'b1;
    e_sys     = 1'b1;
    e_ready   = 1'b0;
    e_fault   = 1'b0;
    e_retry   = 2'd0;
    e_lost    = 1'b0;
  endtask

  task automatic push_exp(input int e);
    ev_t ev;
    ev.at_edge = e;
    ev.vec     = {e_pll_rst, e_sys, e_ready, e_fault, e_retry, e_lost};
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].at_edge == e) exp_q[exp_q.size()-1] = ev;
    else if (ev.vec !== last_pushed) exp_q.push_back(ev);
    last_pushed = ev.vec;
  endtask

  // Always leaves the caller 1 time unit after the target rising edge.
  task automatic goto_edge(input int e);
    while (edge_n < e) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s missing events got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_release();
    int n, w, u;
    n = edge_n + int'($urandom_range(4, 1));
    pll_locked = 1'b1;
    w = n + RP;
    u = w + LS + 3;
    e_pll_rst = 1'b0;
    push_exp(w);
    e_ready = 1'b1;
    e_sys   = 1'b0;
    push_exp(u);
    goto_edge(n);
    rst_n = 1'b1;
    goto_edge(u + 2);
    drain("release");
  endtask

  task automatic apply_lock_loss(input int k_force);
    int d, r, w, p, pe, k, g, u;
    bit glitch;
    d      = edge_n + int'($urandom_range(5, 0));
    r      = d + 3;
    w      = r + RP;
    p      = int'($urandom_range(w + 12, d + 1));
    pe     = (p > w) ? p : w;
    glitch = (k_force > 0) || ($urandom_range(1, 0) == 1);
    k      = (k_force > 0) ? k_force : int'($urandom_range(LS - 1, 1));
    g      = pe + k;
    u      = glitch ? g + 12 : pe + 11;
    e_pll_rst = 1'b1;
    e_sys     = 1'b1;
    e_ready   = 1'b0;
    e_lost    = 1'b1;
    push_exp(r);
    e_pll_rst = 1'b0;
    push_exp(w);
    e_ready = 1'b1;
    e_sys   = 1'b0;
    push_exp(u);
    goto_edge(d);
    pll_locked = 1'b0;
    goto_edge(p);
    pll_locked = 1'b1;
    if (glitch) begin
      goto_edge(g);
      pll_locked = 1'b0;
      goto_edge(g + 1);
      pll_locked = 1'b1;
    end
    goto_edge(u + 2);
    drain("lock_loss");
  endtask

  task automatic apply_fault();
    int d, r, w, t, q, t2, p, pe, u;
    d = edge_n + int'($urandom_range(5, 0));
    r = d + 3;
    e_pll_rst = 1'b1;
    e_sys     = 1'b1;
    e_ready   = 1'b0;
    e_lost    = 1'b1;
    push_exp(r);
    w = r + RP;
    e_pll_rst = 1'b0;
    push_exp(w);
    t = w;
    for (int i = 1; i <= MR; i++) begin
      t = w + TO;
      e_retry   = 2'(i);
      e_pll_rst = 1'b1;
      if (i == MR) e_fault = 1'b1;
      push_exp(t);
      if (i < MR) begin
        w = t + RP;
        e_pll_rst = 1'b0;
        push_exp(w);
      end
    end
    q = t + int'($urandom_range(10, 1));
    r = q + 1;
    e_fault = 1'b0;
    e_retry = 2'd0;
    e_lost  = 1'b0;
    push_exp(r);
    w = r + RP;
    e_pll_rst = 1'b0;
    push_exp(w);
    t = w + TO;
    e_retry   = 2'd1;
    e_pll_rst = 1'b1;
    push_exp(t);
    w = t + RP;
    e_pll_rst = 1'b0;
    push_exp(w);
    // Restart lands on the second timeout edge and must win over the retry.
    t2 = w + TO;
    e_retry   = 2'd0;
    e_pll_rst = 1'b1;
    push_exp(t2);
    w = t2 + RP;
    e_pll_rst = 1'b0;
    push_exp(w);
    p  = t2 + int'($urandom_range(8, 0));
    pe = (p > w) ? p : w;
    u  = pe + 11;
    e_ready = 1'b1;
    e_sys   = 1'b0;
    push_exp(u);
    goto_edge(d);
    pll_locked = 1'b0;
    goto_edge(q);
    restart_req = 1'b1;
    goto_edge(q + 1);
    restart_req = 1'b0;
    goto_edge(t2 - 1);
    restart_req = 1'b1;
    goto_edge(t2);
    restart_req = 1'b0;
    goto_edge(p);
    pll_locked = 1'b1;
    goto_edge(u + 2);
    drain("fault");
  endtask

  task automatic apply_restart_reset();
    int q, r, w, x;
    q = edge_n + int'($urandom_range(5, 0));
    r = q + 1;
    e_pll_rst = 1'b1;
    e_sys     = 1'b1;
    e_ready   = 1'b0;
    push_exp(r);
    w = r + RP;
    e_pll_rst = 1'b0;
    push_exp(w);
    x = w + int'($urandom_range(20, 1));
    reset_exp();
    push_exp(x);
    goto_edge(q);
    restart_req = 1'b1;
    pll_locked  = 1'b0;
    goto_edge(q + 1);
    restart_req = 1'b0;
    goto_edge(x);
    rst_n = 1'b0;
    #2;
    check_output("async_reset", dut_vec(), RESET_VEC);
    goto_edge(x + 3);
    drain("restart_reset");
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_output("reset_state", dut_vec(), RESET_VEC);
    reset_exp();
    for (int it = 0; it < 3; it++) begin
      apply_release();
      apply_lock_loss((it == 0) ? 5 : 0);
      apply_fault();
      apply_restart_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got edge %0d expected completion", edge_n);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
